hdmi_period_scheduler: RTL and testbench

- Per-pixel sequencer for the three tmds_channel instances. Runs the raster counters and, for every pixel, selects the channel mode (0 control, 1 video, 2 video guard, 3 island, 4 island guard), the sync bits and the CTL preamble bits.
- Schedules data-island packets into horizontal blanking, using a valid/ready handshake with the packet source.
- Sits between the top level and the tmds_channel instances.

---
 rtl/hdmi_period_if.sv | 21 ++
 rtl/hdmi_period_scheduler.sv | 158 +++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hdmi_period_if.sv
// hdmi_period_if: packet handshake and per-pixel channel control bundle of the period scheduler
interface hdmi_period_if;
   logic       packet_valid;
   logic [2:0] mode;
   logic [3:0] ctl;
   logic       hsync;
   logic       vsync;
   logic [9:0] cx;
   logic [9:0] cy;
   logic       packet_ready;
   logic [4:0] packet_pixel;
   logic       island_active;
   modport master (
      input  packet_valid,
      output mode, ctl, hsync, vsync, cx, cy, packet_ready, packet_pixel, island_active
   );
   modport slave (
      output packet_valid,
      input  mode, ctl, hsync, vsync, cx, cy, packet_ready, packet_pixel, island_active
   );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: raster counters, per-pixel TMDS period selection and data-island packet scheduling
module hdmi_period_scheduler #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter bit SYNC_ACTIVE = 1'b0,
   parameter int MAX_PACKETS = 2
) (
   input logic           clk_pixel,
   input logic           reset_n,
   hdmi_period_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [9:0] HA   = 10'(H_ACTIVE);
   localparam logic [9:0] HL   = 10'(H_TOTAL - 1);
   localparam logic [9:0] VA   = 10'(V_ACTIVE);
   localparam logic [9:0] VA1  = 10'(V_ACTIVE - 1);
   localparam logic [9:0] VL   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS0  = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS1  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS0  = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VS1  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [9:0] ISL  = 10'(H_ACTIVE + 3);
   localparam logic [9:0] PRE0 = 10'(H_TOTAL - 10);
   localparam logic [9:0] PRE1 = 10'(H_TOTAL - 2);
   // a packet may follow the one ending at x only if it starts early enough to leave room
   // for its 32 pixels, the trailing guard and 12 idle pixels before the video preamble
   localparam logic [9:0] CONT_LIM = 10'(H_TOTAL - 56);
   localparam logic [1:0] MAXP     = 2'(MAX_PACKETS);

   if (H_FRONT + H_SYNC + H_BACK < 14 + 32 * MAX_PACKETS + 2 + 12 + 10) begin : g_bad_blank
      $error("hdmi_period_scheduler: horizontal blanking too short for MAX_PACKETS");
   end
   if (MAX_PACKETS < 1 || MAX_PACKETS > 3) begin : g_bad_max
      $error("hdmi_period_scheduler: MAX_PACKETS must be 1..3");
   end

   typedef enum logic [2:0] {IDLE, DPRE, DLEAD, DATA, DTRAIL} state_t;

   // x/y/st describe the pixel being computed this cycle; it is shown after the next edge
   state_t     st, st_n;
   logic [9:0] x, y;
   logic [4:0] cnt, cnt_n;
   logic [1:0] pk, pk_n;
   logic [2:0] mode_n;
   logic [3:0] ctl_n;
   logic       hs_n, vs_n, pr_n, ia_n;
   logic [4:0] pp_n;

   // raster counters for the pixel under computation
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         x <= '0;
         y <= '0;
      end else begin
         x <= (x == HL) ? '0 : x + 10'd1;
         y <= (x != HL) ? y : (y == VL) ? '0 : y + 10'd1;
      end
   end

   // island state register; reset aborts any island in progress
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         st  <= IDLE;
         cnt <= '0;
         pk  <= '0;
      end else begin
         st  <= st_n;
         cnt <= cnt_n;
         pk  <= pk_n;
      end
   end

   // island next state: cnt is the pixel position within the current phase
   always_comb begin
      st_n  = st;
      cnt_n = cnt + 5'd1;
      pk_n  = pk;
      case (st)
         IDLE: begin
            cnt_n = '0;
            if (x == ISL && bus.packet_valid) st_n = DPRE;
         end
         DPRE: if (cnt == 5'd7) begin
            st_n  = DLEAD;
            cnt_n = '0;
         end
         DLEAD: if (cnt == 5'd1) begin
            st_n  = DATA;
            cnt_n = '0;
            pk_n  = 2'd1;
         end
         DATA: if (cnt == 5'd31) begin
            if (bus.packet_valid && pk < MAXP && x < CONT_LIM) pk_n = pk + 2'd1;
            else st_n = DTRAIL;
         end
         DTRAIL: if (cnt == 5'd1) begin
            st_n  = IDLE;
            cnt_n = '0;
         end
         default: st_n = IDLE;
      endcase
   end

   // per-pixel period decode: video, then island, then video preamble, else control
   always_comb begin
      hs_n   = (x >= HS0 && x < HS1) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_n   = (y >= VS0 && y < VS1) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      mode_n = 3'd0;
      ctl_n  = 4'd0;
      pr_n   = 1'b0;
      pp_n   = 5'd0;
      ia_n   = 1'b0;
      if (y < VA && x < HA) begin
         mode_n = 3'd1;
      end else if (st != IDLE) begin
         ia_n   = 1'b1;
         mode_n = (st == DLEAD || st == DTRAIL) ? 3'd4 : (st == DATA) ? 3'd3 : 3'd0;
         ctl_n  = (st == DPRE) ? 4'b0101 : 4'b0000;
         pp_n   = (st == DATA) ? cnt : 5'd0;
         pr_n   = (st == DATA) && (cnt == 5'd0);
      end else if ((y < VA1 || y == VL) && x >= PRE0) begin
         mode_n = (x >= PRE1) ? 3'd2 : 3'd0;
         ctl_n  = (x >= PRE1) ? 4'b0000 : 4'b0001;
      end
   end

   // registered outputs for the pixel shown this cycle
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         bus.cx            <= '0;
         bus.cy            <= '0;
         bus.mode          <= '0;
         bus.ctl           <= '0;
         bus.hsync         <= ~SYNC_ACTIVE;
         bus.vsync         <= ~SYNC_ACTIVE;
         bus.packet_ready  <= 1'b0;
         bus.packet_pixel  <= '0;
         bus.island_active <= 1'b0;
      end else begin
         bus.cx            <= x;
         bus.cy            <= y;
         bus.mode          <= mode_n;
         bus.ctl           <= ctl_n;
         bus.hsync         <= hs_n;
         bus.vsync         <= vs_n;
         bus.packet_ready  <= pr_n;
         bus.packet_pixel  <= pp_n;
         bus.island_active <= ia_n;
      end
   end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler: vector table plus plan-based reference model for two scheduler instances
module tb_hdmi_period_scheduler;
   localparam int HA = 640, HF = 16, HS = 96, HB = 48;
   localparam int VA = 8, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam logic [35:0] RST = {10'd0, 10'd0, 3'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1};

   logic clk_pixel = 1'b0;
   logic reset_n = 1'b0;
   logic pv = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   hdmi_period_if b0 ();
   hdmi_period_if b1 ();
   assign b0.packet_valid = pv;
   assign b1.packet_valid = pv;

   hdmi_period_scheduler #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(1'b0), .MAX_PACKETS(2))
      u0 (.clk_pixel(clk_pixel), .reset_n(reset_n), .bus(b0));
   hdmi_period_scheduler #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(1'b0), .MAX_PACKETS(3))
      u1 (.clk_pixel(clk_pixel), .reset_n(reset_n), .bus(b1));

   logic [35:0] f[2];
   assign f[0] = {b0.cx, b0.cy, b0.mode, b0.ctl, b0.packet_ready, b0.packet_pixel, b0.island_active, b0.hsync, b0.vsync};
   assign f[1] = {b1.cx, b1.cy, b1.mode, b1.ctl, b1.packet_ready, b1.packet_pixel, b1.island_active, b1.hsync, b1.vsync};

   typedef struct {
      int          ln;
      int          cx;
      int          inst;
      logic [15:0] e;
   } vec_t;
   vec_t tab[$];

   int checks = 0, passed = 0;

   task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic add(input int ln, input int cx, input int inst, input int m, input int c,
                      input int pr, input int pp, input int ia, input int h, input int v);
      vec_t r;
      r.ln = ln; r.cx = cx; r.inst = inst;
      r.e = {3'(m), 4'(c), 1'(pr), 5'(pp), 1'(ia), 1'(h), 1'(v)};
      tab.push_back(r);
   endtask

   // expected outputs for pixel (x,y) given this line's island plan: il = island granted, n = packets granted
   function automatic logic [35:0] model_out(input int x, input int y, input bit il, input int n);
      logic [2:0] m;
      logic [3:0] c;
      logic       pr, ia, h, v;
      logic [4:0] pp;
      m = 0; c = 0; pr = 0; pp = 0; ia = 0;
      h = !(x >= HA + HF && x < HA + HF + HS);
      v = !(y >= VA + VF && y < VA + VF + VS);
      if (y < VA && x < HA) m = 3'd1;
      else if (il && x >= HA + 4 && x < HA + 14 + 32 * n + 2) begin
         ia = 1'b1;
         if (x < HA + 12) c = 4'b0101;
         else if (x < HA + 14 || x >= HA + 14 + 32 * n) m = 3'd4;
         else begin
            m  = 3'd3;
            pp = 5'((x - HA - 14) % 32);
            pr = (pp == 5'd0);
         end
      end else if ((y < VA - 1 || y == VT - 1) && x >= HT - 10) begin
         if (x >= HT - 2) m = 3'd2;
         else c = 4'b0001;
      end
      return {10'(x), 10'(y), m, c, pr, pp, ia, h, v};
   endfunction

   int  mx = 0, my = 0, ln = 0, sx = 0, rhold = 0;
   bit  isl[2], closed[2], mid_done;
   int  np[2];
   int  mmax[2] = '{2, 3};

   initial begin
      // frame 0, packet_valid low: video, preamble and sync placement
      add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
      add(0, 639, 0, 1, 0, 0, 0, 0, 1, 1);
      add(0, 640, 0, 0, 0, 0, 0, 0, 1, 1);
      add(0, 656, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 751, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 752, 0, 0, 0, 0, 0, 0, 1, 1);
      add(0, 789, 0, 0, 0, 0, 0, 0, 1, 1);
      add(0, 790, 0, 0, 1, 0, 0, 0, 1, 1);
      add(0, 797, 0, 0, 1, 0, 0, 0, 1, 1);
      add(0, 798, 0, 2, 0, 0, 0, 0, 1, 1);
      add(0, 799, 0, 2, 0, 0, 0, 0, 1, 1);
      add(7, 639, 0, 1, 0, 0, 0, 0, 1, 1);
      add(7, 790, 0, 0, 0, 0, 0, 0, 1, 1);
      add(8, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      add(10, 100, 0, 0, 0, 0, 0, 0, 1, 0);
      add(11, 700, 0, 0, 0, 0, 0, 0, 0, 0);
      add(12, 100, 0, 0, 0, 0, 0, 0, 1, 1);
      add(14, 790, 0, 0, 1, 0, 0, 0, 1, 1);
      add(14, 798, 0, 2, 0, 0, 0, 0, 1, 1);
      // line 15, packet_valid held high: MAX_PACKETS=2 instance
      add(15, 643, 0, 0, 0, 0, 0, 0, 1, 1);
      add(15, 644, 0, 0, 5, 0, 0, 1, 1, 1);
      add(15, 651, 0, 0, 5, 0, 0, 1, 1, 1);
      add(15, 652, 0, 4, 0, 0, 0, 1, 1, 1);
      add(15, 653, 0, 4, 0, 0, 0, 1, 1, 1);
      add(15, 654, 0, 3, 0, 1, 0, 1, 1, 1);
      add(15, 655, 0, 3, 0, 0, 1, 1, 1, 1);
      add(15, 686, 0, 3, 0, 1, 0, 1, 0, 1);
      add(15, 717, 0, 3, 0, 0, 31, 1, 0, 1);
      add(15, 718, 0, 4, 0, 0, 0, 1, 0, 1);
      add(15, 719, 0, 4, 0, 0, 0, 1, 0, 1);
      add(15, 720, 0, 0, 0, 0, 0, 0, 0, 1);
      // same line, MAX_PACKETS=3 instance
      add(15, 718, 1, 3, 0, 1, 0, 1, 0, 1);
      add(15, 749, 1, 3, 0, 0, 31, 1, 0, 1);
      add(15, 750, 1, 4, 0, 0, 0, 1, 0, 1);
      add(15, 751, 1, 4, 0, 0, 0, 1, 0, 1);
      add(15, 752, 1, 0, 0, 0, 0, 0, 1, 1);
      // line 16, packet_valid dropped after the first packet_ready
      add(16, 654, 0, 3, 0, 1, 0, 1, 1, 1);
      add(16, 685, 0, 3, 0, 0, 31, 1, 0, 1);
      add(16, 686, 0, 4, 0, 0, 0, 1, 0, 1);
      add(16, 687, 0, 4, 0, 0, 0, 1, 0, 1);
      add(16, 688, 0, 0, 0, 0, 0, 0, 0, 1);
      // line 30: mid-packet just before the reset
      add(30, 700, 0, 3, 0, 0, 14, 1, 0, 1);

      repeat (3) begin
         @(posedge clk_pixel); #1;
         chk("reset0", f[0], RST);
         chk("reset1", f[1], RST);
      end
      reset_n = 1'b1;
      for (int n = 0; n < 27000; n++) begin
         bit rs, p;
         rs = reset_n;
         p  = pv;
         @(posedge clk_pixel); #1;
         if (!rs) begin
            chk("abort0", f[0], RST);
            chk("abort1", f[1], RST);
            mx = 0; my = 0;
            for (int i = 0; i < 2; i++) isl[i] = 0;
            rhold--;
            if (rhold == 0) reset_n = 1'b1;
         end else begin
            sx = mx;
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("model%0d", i), f[i], model_out(mx, my, isl[i], np[i]));
               for (int k = 0; k < tab.size(); k++)
                  if (tab[k].inst == i && tab[k].ln == ln && tab[k].cx == mx)
                     chk($sformatf("vec%0d", k), {20'd0, f[i][15:0]}, {20'd0, tab[k].e});
               if (mx == HA + 3) begin
                  isl[i] = p; np[i] = 1; closed[i] = 0;
               end else if (isl[i] && !closed[i] && mx == HA + 13 + 32 * np[i]) begin
                  if (p && np[i] < mmax[i] && HA + 14 + 32 * np[i] + 46 <= HT - 10) np[i]++;
                  else closed[i] = 1;
               end
               if (mx == HT - 1) isl[i] = 0;
            end
            if (mx == HT - 1) begin
               mx = 0;
               my = (my == VT - 1) ? 0 : my + 1;
               ln++;
            end else mx++;
            if (ln == 30 && sx == 700 && !mid_done) begin
               reset_n = 1'b0; rhold = 2; mid_done = 1;
            end
         end
         pv = (ln < 15) ? 1'b0 : (ln == 15 || ln == 30) ? 1'b1 : (ln == 16) ? (mx < 660) : 1'($urandom_range(0, 1));
      end
      checks++;
      if (mid_done) passed++;
      else $display("FAIL midreset: reached %0d required 1", mid_done);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
